ram_sp_param: RTL and testbench
===============================

// Module: ram_sp_param
// PURPOSE
//  Parametrised single-port synchronous RAM. Successor to the fixed 32x4 RAM.
//  Adds configurable width and depth, selectable read latency and read-during-write mode.
//  Adds a hardware clear engine that sweeps every word to CLEAR_VALUE after reset or on request.
//  Per-read data_valid strobe. Shared storage block for lab datapaths; infers block RAM.
// PARAMETERS
//  DATA_WIDTH   4    word width in bits
//  ADDR_WIDTH   5    address width; DEPTH = 2**ADDR_WIDTH words
//  READ_LATENCY 1    1 or 2 clock edges from read accept to data_out/data_valid
//  WRITE_FIRST  0    same-address read during write: 0 returns old word, 1 returns data_in
//  CLEAR_VALUE  '0   DATA_WIDTH value written to every word by the clear engine
// PORTS
//  clk           in   1           clock, rising edge
//  reset         in   1           synchronous, active-high; restarts clear sweep
//  clear         in   1           request a full-memory clear sweep (sampled in IDLE)
//  busy          out  1           1 while clear sweep is running; accesses are ignored
//  address       in   ADDR_WIDTH  read/write address
//  data_in       in   DATA_WIDTH  write data
//  write_enable  in   1           write data_in to address at this edge
//  read_enable   in   1           read address at this edge
//  data_out      out  DATA_WIDTH  read data; holds last value between reads
//  data_valid    out  1           1-cycle pulse: data_out carries an accepted read's result
// BEHAVIOUR
//  Reset (synchronous, active-high):
//   - state<=CLEAR, clear_addr<=0
//   - read pipeline flushed: data_valid=0, data_out=0
//   - busy=1 from the first edge after reset is sampled
//   - reset held high keeps clear_addr at 0
//  FSM states: IDLE, CLEAR. busy = (state==CLEAR), combinational from state.
//   - IDLE->CLEAR: clear=1 sampled at an edge; clear_addr<=0.
//   - CLEAR: each edge writes mem[clear_addr]<=CLEAR_VALUE and increments clear_addr.
//   - CLEAR exit: at clear_addr==DEPTH-1 the last word is written and state<=IDLE.
//   - Sweep is exactly DEPTH edges, so busy is high DEPTH cycles. clear_addr never wraps.
//   - clear asserted during CLEAR is ignored; the sweep does not restart or extend.
//   - reset mid-sweep restarts from address 0.
//  Access (IDLE only; write_enable/read_enable ignored while busy, no data_valid generated):
//   - Write: mem[address]<=data_in at the edge write_enable is sampled.
//   - Read accepted at edge k with read_enable=1:
//     - READ_LATENCY=1: data_out/data_valid update at edge k.
//     - READ_LATENCY=2: data_out/data_valid update at edge k+1 (extra output register).
//   - Back-to-back reads: one result per cycle; data_valid high every cycle.
//   - Read+write same edge (same address): WRITE_FIRST=0 -> old word; WRITE_FIRST=1 -> data_in.
//  Clear vs in-flight reads:
//   - Reads accepted before clear was sampled complete normally with data_valid=1.
//   - reset flushes them.
//  All addresses 0..DEPTH-1 valid; no out-of-range handling needed.
//  Memory contents not initialised by declaration; the post-reset sweep defines them.
// TESTING (run at defaults; repeat 2,3 with READ_LATENCY=2 and WRITE_FIRST=1)
//  1 Pulse reset 1 cycle -> busy high exactly 32 cycles; all 32 reads return 4'h0 with data_valid.
//  2 Write 5'h15<=4'hA, 5'h0A<=4'h5; read 5'h15 -> data_out=4'hA, data_valid after 1 edge (2 if RL=2).
//  3 Fill 5'h03=4'h2; same-edge write 4'h7 + read 5'h03 -> 4'h2 (WRITE_FIRST=0) / 4'h7 (WRITE_FIRST=1).
//  4 Fill all words 4'hF; pulse clear -> busy 32 cycles; mid-sweep write 5'h05<=4'h9 and
//    read_enable are ignored (data_valid stays 0); all reads after sweep -> 4'h0.
//  5 Assert reset at sweep cycle 10 -> busy stays high; exactly 32 cycles after reset drops busy=0.
//  6 Read 5'h0A then pulse clear next cycle -> read completes (data_out=4'h5, data_valid=1);
//    re-pulse clear mid-sweep -> busy still ends at cycle 32.

Source files
------------

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with a hardware clear sweep and
// a configurable-latency read pipeline that raises data_valid on each read.
module ram_sp_param #(
    parameter int unsigned           DATA_WIDTH   = 4,
    parameter int unsigned           ADDR_WIDTH   = 5,
    parameter int unsigned           READ_LATENCY = 1,
    parameter int unsigned           WRITE_FIRST  = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid
);

    localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_addr_q, clear_addr_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word_c;
    logic                    wr_accept_c, rd_accept_c, sweep_we_c;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q;

    // Sweep controller: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    // Sweep controller: next state; address holds at the last word so it never wraps
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d      = CLEAR;
                    clear_addr_d = '0;
                end
            end
            CLEAR: begin
                if (clear_addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clear_addr_d = clear_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign busy        = (state_q == CLEAR);
    assign sweep_we_c  = busy && !reset;
    assign wr_accept_c = !busy && !reset && write_enable;
    assign rd_accept_c = !busy && !reset && read_enable;
    assign rd_word_c   = ((WRITE_FIRST != 0) && write_enable) ? data_in : mem[address];

    // Storage array: left without reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (sweep_we_c) begin
            mem[clear_addr_q] <= CLEAR_VALUE;
        end else if (wr_accept_c) begin
            mem[address] <= data_in;
        end
    end

    // First read stage; data holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept_c;
            if (rd_accept_c) begin
                rd_data_q <= rd_word_c;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_rl2
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_valid_q;

        // Extra output register; keeps running through a sweep so in-flight reads finish
        always_ff @(posedge clk) begin
            if (reset) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) begin
                    out_data_q <= rd_data_q;
                end
            end
        end

        assign data_out   = out_data_q;
        assign data_valid = out_valid_q;
    end else begin : g_rl1
        assign data_out   = rd_data_q;
        assign data_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_ram_sp_param.sv
// Scoreboard bench for ram_sp_param: reads push expected word and due cycle,
// the negedge monitor pops and checks data, validity and latency.
module tb_ram_sp_param;

    parameter int unsigned RL = 1;
    parameter int unsigned WF = 0;

    localparam int unsigned DW    = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, clear, write_enable, read_enable;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic          busy, data_valid;
    logic [DW-1:0] data_out;

    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    bit            mon_on = 1'b0;
    exp_t          sb_q[$];
    logic [DW-1:0] model [DEPTH];

    ram_sp_param #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL),
        .WRITE_FIRST (WF),
        .CLEAR_VALUE (4'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .busy        (busy),
        .address     (address),
        .data_in     (data_in),
        .write_enable(write_enable),
        .read_enable (read_enable),
        .data_out    (data_out),
        .data_valid  (data_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_on) begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) void'(sb_q.pop_front());
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                check("data_valid", 32'(data_valid), 32'd1);
                check("data_out", 32'(data_out), 32'(sb_q[0].data));
                void'(sb_q.pop_front());
            end else begin
                check("no_valid", 32'(data_valid), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        address = a; data_in = d; write_enable = 1'b1;
        model[a] = d;
        step();
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        exp_t e;
        e.due = cyc + int'(RL);
        e.data = model[a];
        sb_q.push_back(e);
        address = a; read_enable = 1'b1;
        step();
    endtask

    task automatic do_rw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.due = cyc + int'(RL);
        e.data = (WF != 0) ? d : model[a];
        sb_q.push_back(e);
        model[a] = d;
        address = a; data_in = d; write_enable = 1'b1; read_enable = 1'b1;
        step();
    endtask

    // Counts busy cycles; optionally re-pulses clear or tries an access mid-sweep
    task automatic measure_busy(input int repulse_at, input int access_at, output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == repulse_at) clear = 1'b1;
            if (n == access_at) begin
                address = 5'h05; data_in = 4'h9;
                write_enable = 1'b1; read_enable = 1'b1;
            end
            step();
        end
        for (int i = 0; i < DEPTH; i++) model[i] = 4'h0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
    endtask

    initial begin
        int n;
        reset = 1'b1; clear = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
        address = '0; data_in = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        mon_on = 1'b1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);

        // 1: sweep after reset, all words cleared
        measure_busy(0, 0, n);
        check("reset_sweep_len", n, 32'd32);
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i));
        step();

        // 2: basic write/read
        do_write(5'h15, 4'hA);
        do_write(5'h0A, 4'h5);
        do_read(5'h15);
        do_read(5'h0A);
        step(); step();

        // 3: same-edge read and write
        do_write(5'h03, 4'h2);
        do_rw(5'h03, 4'h7);
        do_read(5'h03);
        step(); step();

        // 4: fill, clear, ignored mid-sweep access
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 4'hF);
        do_read(5'h1F);
        pulse_clear();
        measure_busy(0, 20, n);
        check("clear_sweep_len", n, 32'd32);
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i));
        step(); step();

        // 5: reset mid-sweep restarts the sweep
        do_write(5'h07, 4'h3);
        pulse_clear();
        for (int i = 0; i < 10; i++) step();
        check("busy_mid_sweep", 32'(busy), 32'd1);
        reset = 1'b1;
        sb_q.delete();
        step();
        reset = 1'b0;
        check("busy_after_reset", 32'(busy), 32'd1);
        measure_busy(0, 0, n);
        check("restart_sweep_len", n, 32'd32);
        do_read(5'h07);
        step(); step();

        // 6: in-flight read survives clear; re-pulsed clear does not extend
        do_write(5'h0A, 4'h5);
        do_read(5'h0A);
        pulse_clear();
        measure_busy(15, 0, n);
        check("repulse_sweep_len", n, 32'd32);
        do_read(5'h0A);
        for (int i = 0; i < 4; i++) step();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
